// File: rtl/dct_pkg.sv
// dct_pkg: Q8 DCT coefficients and scaling constants shared by the dct datapath
package dct_pkg;
  localparam int C_91    = 91;
  localparam int C_126   = 126;
  localparam int C_118   = 118;
  localparam int C_106   = 106;
  localparam int C_71    = 71;
  localparam int C_49    = 49;
  localparam int C_25    = 25;
  localparam int Q_SHIFT = 8;
  localparam int RND     = 128;
endpackage

// File: rtl/dct_mac4.sv
// dct_mac4: registered 4-term constant-coefficient signed dot product (DCT_SCALE_EN adds Q8 round-and-shift)
module dct_mac4
  import dct_pkg::*;
#(
  parameter int W     = 16,
  parameter int OUT_W = 32,
  parameter int K1    = 0,
  parameter int K2    = 0,
  parameter int K3    = 0,
  parameter int K4    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0][W-1:0]       a_i,
  output logic signed [OUT_W-1:0] z_o
);
  logic signed [OUT_W-1:0] sum, z_d, z_q;
  function automatic logic signed [OUT_W-1:0] cmul(input logic signed [W-1:0] a, input int k);
    logic signed [OUT_W-1:0] ext, acc;
    int m;
    ext = OUT_W'(a);
    m   = k < 0 ? -k : k;
    acc = '0;
    for (int b = 0; b < 8; b++)
      if (m[b]) acc = acc + (ext <<< b);
    return k < 0 ? -acc : acc;
  endfunction
  // shift-add products summed, then optionally rounded back out of Q8
  always_comb begin
    sum = cmul(a_i[0], K1) + cmul(a_i[1], K2) + cmul(a_i[2], K3) + cmul(a_i[3], K4);
`ifdef DCT_SCALE_EN
    z_d = (sum + OUT_W'(RND)) >>> Q_SHIFT;
`else
    z_d = sum;
`endif
  end
  // output register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) z_q <= '0;
    else        z_q <= z_d;
  assign z_o = z_q;
endmodule

// File: rtl/dct.sv
// dct: pipelined 8-point 1-D DCT-II, Q8 coefficients, 2-cycle latency (DCT_SCALE_EN selects scaled output)
module dct
  import dct_pkg::*;
#(
  parameter int IN_W  = 15,
  parameter int OUT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [IN_W-1:0]  x1_i,
  input  logic signed [IN_W-1:0]  x2_i,
  input  logic signed [IN_W-1:0]  x3_i,
  input  logic signed [IN_W-1:0]  x4_i,
  input  logic signed [IN_W-1:0]  x5_i,
  input  logic signed [IN_W-1:0]  x6_i,
  input  logic signed [IN_W-1:0]  x7_i,
  input  logic signed [IN_W-1:0]  x8_i,
  output logic signed [OUT_W-1:0] z1_o,
  output logic signed [OUT_W-1:0] z2_o,
  output logic signed [OUT_W-1:0] z3_o,
  output logic signed [OUT_W-1:0] z4_o,
  output logic signed [OUT_W-1:0] z5_o,
  output logic signed [OUT_W-1:0] z6_o,
  output logic signed [OUT_W-1:0] z7_o,
  output logic signed [OUT_W-1:0] z8_o
);
  localparam int W1 = IN_W + 1;
  logic [3:0][W1-1:0] s_d, s_q, d_d, d_q;
  // mirrored-pair butterflies: even terms feed sums, odd terms feed differences
  always_comb begin
    s_d[0] = W1'(x1_i) + W1'(x8_i);
    s_d[1] = W1'(x2_i) + W1'(x7_i);
    s_d[2] = W1'(x3_i) + W1'(x6_i);
    s_d[3] = W1'(x4_i) + W1'(x5_i);
    d_d[0] = W1'(x1_i) - W1'(x8_i);
    d_d[1] = W1'(x2_i) - W1'(x7_i);
    d_d[2] = W1'(x3_i) - W1'(x6_i);
    d_d[3] = W1'(x4_i) - W1'(x5_i);
  end
  // stage-1 butterfly registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_q <= '0;
      d_q <= '0;
    end else begin
      s_q <= s_d;
      d_q <= d_d;
    end
  dct_mac4 #(.W(W1), .OUT_W(OUT_W), .K1(C_91),  .K2(C_91),   .K3(C_91),   .K4(C_91))
    u_z1 (.clk(clk), .rst_n(rst_n), .a_i(s_q), .z_o(z1_o));
  dct_mac4 #(.W(W1), .OUT_W(OUT_W), .K1(C_126), .K2(C_106),  .K3(C_71),   .K4(C_25))
    u_z2 (.clk(clk), .rst_n(rst_n), .a_i(d_q), .z_o(z2_o));
  dct_mac4 #(.W(W1), .OUT_W(OUT_W), .K1(C_118), .K2(C_49),   .K3(-C_49),  .K4(-C_118))
    u_z3 (.clk(clk), .rst_n(rst_n), .a_i(s_q), .z_o(z3_o));
  dct_mac4 #(.W(W1), .OUT_W(OUT_W), .K1(C_106), .K2(-C_25),  .K3(-C_126), .K4(-C_71))
    u_z4 (.clk(clk), .rst_n(rst_n), .a_i(d_q), .z_o(z4_o));
  dct_mac4 #(.W(W1), .OUT_W(OUT_W), .K1(C_91),  .K2(-C_91),  .K3(-C_91),  .K4(C_91))
    u_z5 (.clk(clk), .rst_n(rst_n), .a_i(s_q), .z_o(z5_o));
  dct_mac4 #(.W(W1), .OUT_W(OUT_W), .K1(C_71),  .K2(-C_126), .K3(C_25),   .K4(C_106))
    u_z6 (.clk(clk), .rst_n(rst_n), .a_i(d_q), .z_o(z6_o));
  dct_mac4 #(.W(W1), .OUT_W(OUT_W), .K1(C_49),  .K2(-C_118), .K3(C_118),  .K4(-C_49))
    u_z7 (.clk(clk), .rst_n(rst_n), .a_i(s_q), .z_o(z7_o));
  dct_mac4 #(.W(W1), .OUT_W(OUT_W), .K1(C_25),  .K2(-C_71),  .K3(C_106),  .K4(-C_126))
    u_z8 (.clk(clk), .rst_n(rst_n), .a_i(d_q), .z_o(z8_o));
endmodule

// File: tb/tb_dct.sv
// tb_dct: table vectors, random pipelined stream and async reset checks against a cosine-derived DCT model
module tb_dct;
  typedef logic [7:0][31:0] vec8_t;
  typedef struct packed {
    vec8_t x;
    vec8_t z;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [14:0] x [8];
  logic signed [31:0] z [8];
  int n_cmp = 0;
  int n_err = 0;
  int cm [8][8];
  vec_t tbl [5];
  vec8_t hist [40];
  always #5 clk = ~clk;
  dct dut (
    .clk(clk), .rst_n(rst_n),
    .x1_i(x[0]), .x2_i(x[1]), .x3_i(x[2]), .x4_i(x[3]),
    .x5_i(x[4]), .x6_i(x[5]), .x7_i(x[6]), .x8_i(x[7]),
    .z1_o(z[0]), .z2_o(z[1]), .z3_o(z[2]), .z4_o(z[3]),
    .z5_o(z[4]), .z6_o(z[5]), .z7_o(z[6]), .z8_o(z[7])
  );
  function automatic longint scl(longint r);
`ifdef DCT_SCALE_EN
    return (r + 128) >>> 8;
`else
    return r;
`endif
  endfunction
  function automatic longint model(int k, vec8_t v);
    longint acc = 0;
    for (int n = 0; n < 8; n++) acc += longint'(cm[k][n]) * longint'($signed(v[n]));
    return scl(acc);
  endfunction
  task automatic chk(string nm, int k, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s z%0d: got %0d expected %0d", nm, k + 1, act, exp);
    end
  endtask
  task automatic drive(vec8_t v);
    for (int i = 0; i < 8; i++) x[i] = v[i][14:0];
  endtask
  task automatic chk_model(string nm, vec8_t v);
    for (int k = 0; k < 8; k++) chk(nm, k, longint'(z[k]), model(k, v));
  endtask
  task automatic chk_zero(string nm);
    for (int k = 0; k < 8; k++) chk(nm, k, longint'(z[k]), 0);
  endtask
  function automatic vec8_t rnd_vec(int t);
    vec8_t v;
    for (int i = 0; i < 8; i++)
      v[i] = (t % 9 == 4) ? 32'(16383) : (t % 9 == 7) ? -32'(16384) : 32'(int'($urandom_range(32767)) - 16384);
    return v;
  endfunction
  initial begin
    int xi [5][8] = '{'{100, 100, 100, 100, 100, 100, 100, 100},
                      '{1000, 0, 0, 0, 0, 0, 0, 0},
                      '{1000, -1000, 1000, -1000, 1000, -1000, 1000, -1000},
                      '{16383, 16383, 16383, 16383, 16383, 16383, 16383, 16383},
                      '{-16384, -16384, -16384, -16384, -16384, -16384, -16384, -16384}};
    int ei [5][8] = '{'{72800, 0, 0, 0, 0, 0, 0, 0},
                      '{91000, 126000, 118000, 106000, 91000, 71000, 49000, 25000},
                      '{0, 132000, 0, 152000, 0, 232000, 0, 656000},
                      '{11926824, 0, 0, 0, 0, 0, 0, 0},
                      '{-11927552, 0, 0, 0, 0, 0, 0, 0}};
    vec8_t v;
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++) begin
        real c, r;
        c = (k == 0) ? 1.0 / $sqrt(8.0) : 0.5;
        r = 256.0 * c * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
        cm[k][n] = r >= 0.0 ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
      end
    for (int i = 0; i < 5; i++)
      for (int n = 0; n < 8; n++) begin
        tbl[i].x[n] = xi[i][n];
        tbl[i].z[n] = 32'(scl(longint'(ei[i][n])));
      end
    for (int i = 0; i < 8; i++) x[i] = '0;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset_state");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) drive(tbl[i].x);
      @(posedge clk);
      @(posedge clk);
      #1;
      for (int k = 0; k < 8; k++)
        chk($sformatf("table%0d", i), k, longint'(z[k]), longint'($signed(tbl[i].z[k])));
    end
    for (int t = 0; t < 42; t++) begin
      @(negedge clk);
      if (t >= 2) chk_model($sformatf("pipe%0d", t - 2), hist[t - 2]);
      if (t < 40) begin
        hist[t] = rnd_vec(t);
        drive(hist[t]);
      end
    end
    @(negedge clk) drive(rnd_vec(1));
    @(negedge clk) drive(rnd_vec(2));
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    @(posedge clk);
    #1 chk_zero("reset_hold");
    v = rnd_vec(3);
    @(negedge clk);
    rst_n = 1'b1;
    drive(v);
    @(posedge clk);
    #1 chk_zero("post_reset_edge1");
    @(posedge clk);
    #1 chk_model("post_reset_edge2", v);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
